dsp_mode_sequencer: RTL
=======================

# dsp_mode_sequencer

Click-free mode-switch controller for the DSP subsystem. It owns the 2-bit `selector` that chooses between bypass, echo and FIR. When a different mode is requested, it ramps the processed audio down to silence and switches the selector. It then holds mute while the newly selected path's pipeline flushes, and ramps back up. It sits between the front-panel mode switches and the DSP subsystem, and post-scales the subsystem's output.

## Interface
- `RAMP_SHIFT`, 6, ramp length is 2^RAMP_SHIFT sample strobes; gain is unsigned Q0.RAMP_SHIFT, with full scale = 2^RAMP_SHIFT.
- `SETTLE_SAMPLES`, 65, muted strobes after a switch (≥ FIR tap count); 16-bit counter.
- `DEBOUNCE_SAMPLES`, 16, stable strobes required before a request is accepted (only with debounce enabled).
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `sample_strobe`  in  1  one-clock pulse per audio sample; all sample-rate activity advances only on a strobe.
- `mode_request`  in  2  requested mode: 00 bypass, 01 echo, 10 FIR, 11 invalid.
- `processed_sample`  in  16  signed output of the DSP subsystem.
- `selector`  out  2  drives the DSP subsystem mode select.
- `output_sample`  out  16  signed, gain-scaled audio.
- `active_mode`  out  2  mode currently applied to `selector`.
- `busy`  out  1  high in every state except RUN.

## Operation
- Reset values: state RUN, `selector`=00, `active_mode`=00, pending=00, gain=full, settle count=0, `output_sample`=0, `busy`=0.
- Request acceptance happens on a strobe. An 11 request is ignored and pending is unchanged. A valid accepted request overwrites the pending register in every state.
- Scaling: `output_sample` = (`processed_sample` × gain) >>> RAMP_SHIFT.
  - Signed product is 17+RAMP_SHIFT bits; use an arithmetic shift (truncation toward −∞).
  - At gain = full scale, `processed_sample` passes exactly (bypassed multiply).
  - At gain = 0, output is 0.
- State machine:
  - **RUN**: gain full. If pending ≠ active, go to FADE_OUT.
  - **FADE_OUT**: gain −1 per strobe. If pending == active, go to FADE_IN from the current gain. When gain reaches 0, go to SWITCH.
  - **SWITCH**: one clock, no strobe needed. `selector` and `active_mode` take pending. Settle counter loads SETTLE_SAMPLES. Go to SETTLE.
  - **SETTLE**: gain held 0. Counter −1 per strobe. When it reaches 0, go to FADE_IN. Requests are latched but cause no transition.
  - **FADE_IN**: gain +1 per strobe. If pending ≠ active, go to FADE_OUT from the current gain (no jump). When gain reaches full, go to RUN.
- Gain never under- or overflows: it saturates at 0 and at full scale.
- A request equal to `active_mode` in RUN causes no activity.

## Timing
- `output_sample` registers on the clock where `sample_strobe`=1, using the gain value before that strobe's update. Latency is 1 clock.
- All state, gain and counter updates happen on the strobe clock.
  - Exception: SWITCH lasts exactly one clock.
  - A strobe coinciding with the SWITCH clock is still used for the output, at gain 0.
- Full switch, no interruption: 2^RAMP_SHIFT strobes fade + 1 clock + SETTLE_SAMPLES strobes + 2^RAMP_SHIFT strobes fade.
- `busy` rises on the clock after the strobe that accepts a differing request. It falls on the clock gain reaches full.
- Reset asserted mid-operation overrides everything on that clock and returns all outputs to their reset values.

## Configuration
- `DSP_MODE_DEBOUNCE_EN` defined:
  - `mode_request` is sampled on each strobe.
  - A count restarts whenever the value changes.
  - The value is accepted only after DEBOUNCE_SAMPLES consecutive equal strobes, then once per stable period.
- Undefined: `mode_request` is accepted directly on every strobe.

## Structure
- Shared package `dsp_pkg`:
  - Mode constants `MODE_BYPASS`=00, `MODE_ECHO`=01, `MODE_FIR`=10, `MODE_INVALID`=11.
  - The sequencer state enum (RUN, FADE_OUT, SWITCH, SETTLE, FADE_IN).
- One sub-module, `mode_debounce` (request sampler, counter, accept pulse), instantiated only under `DSP_MODE_DEBOUNCE_EN`.

## Test plan
Bench parameters: RAMP_SHIFT=2, SETTLE_SAMPLES=3, DEBOUNCE_SAMPLES=2, `processed_sample`=+1000 constant.
- **Reset**: assert for 2 clocks → `selector`=00, `output_sample`=0, `busy`=0. At first strobe after release → `output_sample`=1000.
- **Full switch**: request 10 (debounce off) → outputs 1000, 750, 500, 250, then 0 ×3 with `selector`=10 after the 4th strobe, then 0, 250, 500, 750, 1000. `busy` falls with full gain.
- **Reversal**: request 01, then request 00 after 2 fade strobes → gain returns 2→3→4. `selector` stays 00; no SWITCH occurs.
- **Invalid**: request 11 in RUN → no state change, `busy`=0, output 1000. Negative-value check: `processed_sample`=−1001 at gain 1 → −251.
- **Retarget in fade-in**: request 10 during SETTLE toward 01 → after SETTLE, FADE_IN begins, then the next strobe reverses to FADE_OUT. The final `selector`=10.
- **Debounce** (`DSP_MODE_DEBOUNCE_EN`): request toggles 01/00 every strobe → never accepted. Request held 01 for 2 strobes → FADE_OUT starts on the next strobe.

Source files
------------

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared mode encodings and sequencer state type for the DSP subsystem
package dsp_pkg;
  localparam logic [1:0] MODE_BYPASS  = 2'b00;
  localparam logic [1:0] MODE_ECHO    = 2'b01;
  localparam logic [1:0] MODE_FIR     = 2'b10;
  localparam logic [1:0] MODE_INVALID = 2'b11;
  typedef enum logic [2:0] {
    ST_RUN,
    ST_FADE_OUT,
    ST_SWITCH,
    ST_SETTLE,
    ST_FADE_IN
  } seq_state_e;
endpackage

// File: rtl/dsp_mode_debounce.sv
// mode_debounce: accepts a mode request after SAMPLES consecutive equal strobes, once per stable period
module mode_debounce #(
  parameter int SAMPLES = 16
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       strobe_i,
  input  logic [1:0] request_i,
  output logic       accept_o
);
  localparam logic [15:0] CAP = 16'(SAMPLES);
  logic [1:0]  last_q;
  logic [15:0] cnt_q, cnt_d;
  logic        same;
  always_comb begin
    same     = request_i == last_q;
    cnt_d    = !same ? 16'd1 : (cnt_q == CAP ? CAP : cnt_q + 16'd1);
    accept_o = strobe_i && cnt_d == CAP && !(same && cnt_q == CAP);
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      last_q <= 2'b00;
      cnt_q  <= 16'd0;
    end else if (strobe_i) begin
      last_q <= request_i;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/dsp_mode_sequencer.sv
// dsp_mode_sequencer: click-free mode switch (fade out, switch, settle muted, fade in); DSP_MODE_DEBOUNCE_EN adds request debounce
module dsp_mode_sequencer
  import dsp_pkg::*;
#(
  parameter int RAMP_SHIFT       = 6,
  parameter int SETTLE_SAMPLES   = 65,
  parameter int DEBOUNCE_SAMPLES = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        sample_strobe_i,
  input  logic [1:0]  mode_request_i,
  input  logic [15:0] processed_sample_i,
  output logic [1:0]  selector_o,
  output logic [15:0] output_sample_o,
  output logic [1:0]  active_mode_o,
  output logic        busy_o
);
  localparam int PW = 17 + RAMP_SHIFT;
  localparam logic [RAMP_SHIFT:0] FULL  = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [RAMP_SHIFT:0] G_ONE = {{RAMP_SHIFT{1'b0}}, 1'b1};
  seq_state_e state_q, state_d;
  logic [RAMP_SHIFT:0] gain_q, gain_d, g_dec, g_inc;
  logic [15:0] cnt_q, cnt_d, out_q, out_d, scaled;
  logic [1:0]  pend_q, pend_d, act_q, act_d, pend_eff;
  logic        accept, mism;
  logic signed [PW-1:0] op_a, op_b, prod;
`ifdef DSP_MODE_DEBOUNCE_EN
  logic db_accept;
  mode_debounce #(.SAMPLES(DEBOUNCE_SAMPLES)) u_debounce (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .strobe_i  (sample_strobe_i),
    .request_i (mode_request_i),
    .accept_o  (db_accept)
  );
  assign accept = db_accept && mode_request_i != MODE_INVALID;
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_SAMPLES;
  assign accept = sample_strobe_i && mode_request_i != MODE_INVALID;
`endif
  // Q0.RAMP_SHIFT gain; full scale bypasses the multiplier so audio passes bit-exact
  assign op_a   = PW'($signed(processed_sample_i));
  assign op_b   = PW'({1'b0, gain_q});
  assign prod   = op_a * op_b;
  assign scaled = gain_q == FULL ? processed_sample_i : 16'(prod >>> RAMP_SHIFT);
  always_comb begin
    pend_eff = accept ? mode_request_i : pend_q;
    mism     = pend_eff != act_q;
    g_dec    = gain_q == '0 ? '0 : gain_q - G_ONE;
    g_inc    = gain_q == FULL ? FULL : gain_q + G_ONE;
    state_d  = state_q;
    gain_d   = gain_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    pend_d   = pend_eff;
    out_d    = sample_strobe_i ? scaled : out_q;
    unique case (state_q)
      ST_RUN: state_d = sample_strobe_i && mism ? ST_FADE_OUT : ST_RUN;
      ST_FADE_OUT:
        if (sample_strobe_i) begin
          if (!mism) state_d = ST_FADE_IN;
          else begin
            gain_d  = g_dec;
            state_d = g_dec == '0 ? ST_SWITCH : ST_FADE_OUT;
          end
        end
      ST_SWITCH: begin
        act_d   = pend_q;
        cnt_d   = 16'(SETTLE_SAMPLES);
        state_d = ST_SETTLE;
      end
      ST_SETTLE:
        if (sample_strobe_i) begin
          cnt_d   = cnt_q == 16'd0 ? 16'd0 : cnt_q - 16'd1;
          state_d = cnt_q <= 16'd1 ? ST_FADE_IN : ST_SETTLE;
        end
      ST_FADE_IN:
        if (sample_strobe_i) begin
          if (mism) state_d = ST_FADE_OUT;
          else begin
            gain_d  = g_inc;
            state_d = g_inc == FULL ? ST_RUN : ST_FADE_IN;
          end
        end
      default: state_d = ST_RUN;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      gain_q  <= FULL;
      cnt_q   <= 16'd0;
      pend_q  <= MODE_BYPASS;
      act_q   <= MODE_BYPASS;
      out_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      out_q   <= out_d;
    end
  end
  assign selector_o      = act_q;
  assign active_mode_o   = act_q;
  assign output_sample_o = out_q;
  assign busy_o          = state_q != ST_RUN;
endmodule
